// File: rtl/vga_pkg.sv
// Shared raster constants and region state types for the VGA 640x480@60 timing generator.
package vga_pkg;

   localparam int unsigned CNT_W = 10;

   localparam int unsigned H_SYNC_END = 95;
   localparam int unsigned H_BACK_END = 143;
   localparam int unsigned H_ACT_END  = 783;
   localparam int unsigned H_TOTAL    = 800;

   localparam int unsigned V_SYNC_END = 1;
   localparam int unsigned V_BACK_END = 34;
   localparam int unsigned V_ACT_END  = 514;
   localparam int unsigned V_TOTAL    = 525;

   // Axis-independent region coding; h_state_t / v_state_t share this encoding.
   typedef enum logic [1:0] {
      R_SYNC   = 2'd0,
      R_BACK   = 2'd1,
      R_ACTIVE = 2'd2,
      R_FRONT  = 2'd3
   } region_t;

   typedef enum logic [1:0] {
      H_SYNC   = 2'd0,
      H_BACK   = 2'd1,
      H_ACTIVE = 2'd2,
      H_FRONT  = 2'd3
   } h_state_t;

   typedef enum logic [1:0] {
      V_SYNC   = 2'd0,
      V_BACK   = 2'd1,
      V_ACTIVE = 2'd2,
      V_FRONT  = 2'd3
   } v_state_t;

endpackage

// File: rtl/vga_axis_ctr.sv
// One raster axis: modulo counter plus sync/back/active/front region FSM and registered sync level.
module vga_axis_ctr
   import vga_pkg::*;
#(
   parameter int unsigned SYNC_END = 95,
   parameter int unsigned BACK_END = 143,
   parameter int unsigned ACT_END  = 783,
   parameter int unsigned TOTAL    = 800
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             adv,
   output logic [CNT_W-1:0] count,
   output logic [1:0]       state,
   output logic             wrap,
   output logic             sync
);

   region_t st;

   assign state = st;
   assign wrap  = adv && (count == CNT_W'(TOTAL - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         st    <= R_SYNC;
         sync  <= 1'b0;
      end else if (adv) begin
         count <= wrap ? '0 : count + CNT_W'(1);
         case (st)
            R_SYNC: if (count == CNT_W'(SYNC_END)) begin
               st   <= R_BACK;
               sync <= 1'b1;
            end
            R_BACK:   if (count == CNT_W'(BACK_END)) st <= R_ACTIVE;
            R_ACTIVE: if (count == CNT_W'(ACT_END))  st <= R_FRONT;
            R_FRONT: if (wrap) begin
               st   <= R_SYNC;
               sync <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA 640x480@60 raster timing generator advancing on pix_en; optional frame_cnt under VGA_FRAME_CNT_EN.
module vga_timing_gen
   import vga_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pix_en,
`ifdef VGA_FRAME_CNT_EN
   output logic [15:0]      frame_cnt,
`endif
   output logic [CNT_W-1:0] hCount,
   output logic [CNT_W-1:0] vCount,
   output logic             hsync,
   output logic             vsync,
   output logic             on,
   output logic             line_start,
   output logic             frame_start
);

   logic [1:0] h_st_raw;
   logic [1:0] v_st_raw;
   h_state_t   h_state;
   v_state_t   v_state;
   logic       h_wrap;
   logic       v_wrap;
   logic       h_act_nxt;
   logic       v_act_nxt;

   vga_axis_ctr #(
      .SYNC_END (H_SYNC_END),
      .BACK_END (H_BACK_END),
      .ACT_END  (H_ACT_END),
      .TOTAL    (H_TOTAL)
   ) u_h (
      .clk     (clk),
      .reset_n (reset_n),
      .adv     (pix_en),
      .count   (hCount),
      .state   (h_st_raw),
      .wrap    (h_wrap),
      .sync    (hsync)
   );

   // The vertical axis steps only on the tick where the line wraps.
   vga_axis_ctr #(
      .SYNC_END (V_SYNC_END),
      .BACK_END (V_BACK_END),
      .ACT_END  (V_ACT_END),
      .TOTAL    (V_TOTAL)
   ) u_v (
      .clk     (clk),
      .reset_n (reset_n),
      .adv     (h_wrap),
      .count   (vCount),
      .state   (v_st_raw),
      .wrap    (v_wrap),
      .sync    (vsync)
   );

   assign h_state = h_state_t'(h_st_raw);
   assign v_state = v_state_t'(v_st_raw);

   // Active flags as they will be after this edge, so 'on' lines up with the new counters.
   assign h_act_nxt = pix_en
      ? ((h_state == H_ACTIVE) && (hCount != CNT_W'(H_ACT_END))) ||
        ((h_state == H_BACK)   && (hCount == CNT_W'(H_BACK_END)))
      : (h_state == H_ACTIVE);
   assign v_act_nxt = h_wrap
      ? ((v_state == V_ACTIVE) && (vCount != CNT_W'(V_ACT_END))) ||
        ((v_state == V_BACK)   && (vCount == CNT_W'(V_BACK_END)))
      : (v_state == V_ACTIVE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         on          <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         on          <= h_act_nxt && v_act_nxt;
         line_start  <= h_wrap;
         frame_start <= v_wrap;
      end
   end

`ifdef VGA_FRAME_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         frame_cnt <= '0;
      end else if (v_wrap) begin
         frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen; covers frame_cnt when built with VGA_FRAME_CNT_EN.
module tb_vga_timing_gen;

   localparam int LIMIT = 500000;

   logic       clk;
   logic       reset_n;
   logic       pix_en;
   logic [9:0] hCount;
   logic [9:0] vCount;
   logic       hsync;
   logic       vsync;
   logic       on;
   logic       line_start;
   logic       frame_start;
`ifdef VGA_FRAME_CNT_EN
   logic [15:0] frame_cnt;
`endif

   int checks = 0;
   int errors = 0;

   int ph [4] = '{798, 799, 0, 1};
   int pv [4] = '{35, 35, 36, 36};
   int pl [4] = '{0, 0, 1, 0};

   vga_timing_gen dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pix_en      (pix_en),
`ifdef VGA_FRAME_CNT_EN
      .frame_cnt   (frame_cnt),
`endif
      .hCount      (hCount),
      .vCount      (vCount),
      .hsync       (hsync),
      .vsync       (vsync),
      .on          (on),
      .line_start  (line_start),
      .frame_start (frame_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      pix_en = 1'b1;
      @(negedge clk);
      pix_en = 1'b0;
   endtask

   task automatic run_to(input int h, input int v);
      int n;
      n = 0;
      pix_en = 1'b1;
      while (!(hCount == 10'(h) && vCount == 10'(v)) && n < LIMIT) begin
         @(negedge clk);
         n++;
      end
      pix_en = 1'b0;
      check("reach_h", 32'(hCount), 32'(h));
      check("reach_v", 32'(vCount), 32'(v));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_h"},     32'(hCount),      0);
      check({tag, "_v"},     32'(vCount),      0);
      check({tag, "_hsync"}, 32'(hsync),       0);
      check({tag, "_vsync"}, 32'(vsync),       0);
      check({tag, "_on"},    32'(on),          0);
      check({tag, "_ls"},    32'(line_start),  0);
      check({tag, "_fs"},    32'(frame_start), 0);
`ifdef VGA_FRAME_CNT_EN
      check({tag, "_fcnt"},  32'(frame_cnt),   0);
`endif
   endtask

   initial begin
      reset_n = 1'b0;
      pix_en  = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("rst");
      reset_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("rel");

      // hsync low across hCount 0..95, high at 96
      pix_en = 1'b1;
      for (int i = 1; i <= 96; i++) begin
         @(negedge clk);
         check("hsweep_h", 32'(hCount), 32'(i));
         check("hsweep_hsync", 32'(hsync), (i <= 95) ? 0 : 1);
         check("hsweep_vsync", 32'(vsync), 0);
      end
      pix_en = 1'b0;

      // first line wrap
      run_to(799, 0);
      check("l0_ls_before", 32'(line_start), 0);
      tick();
      check("lwrap_h", 32'(hCount), 0);
      check("lwrap_v", 32'(vCount), 1);
      check("lwrap_ls", 32'(line_start), 1);
      check("lwrap_fs", 32'(frame_start), 0);
      check("lwrap_hsync", 32'(hsync), 0);
      @(negedge clk);
      check("lwrap_ls_drop", 32'(line_start), 0);

      // vsync leaves sync at vCount 2
      run_to(799, 1);
      check("v1_vsync", 32'(vsync), 0);
      tick();
      check("v2_v", 32'(vCount), 2);
      check("v2_vsync", 32'(vsync), 1);

      // active window edges on the first visible line
      run_to(143, 35);
      check("on_pre", 32'(on), 0);
      tick();
      check("on_rise_h", 32'(hCount), 144);
      check("on_rise", 32'(on), 1);
      run_to(783, 35);
      check("on_hold", 32'(on), 1);
      tick();
      check("on_fall_h", 32'(hCount), 784);
      check("on_fall", 32'(on), 0);

      // sparse ticks, one every 4th clk, across a line wrap
      run_to(797, 35);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("sp_h", 32'(hCount), 32'(ph[i]));
         check("sp_v", 32'(vCount), 32'(pv[i]));
         check("sp_ls", 32'(line_start), 32'(pl[i]));
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("sp_hold_h", 32'(hCount), 32'(ph[i]));
            check("sp_hold_ls", 32'(line_start), 0);
         end
      end

      // asynchronous reset mid-frame with pix_en high
      run_to(400, 200);
      check("mid_hsync", 32'(hsync), 1);
      pix_en = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      check_reset_outputs("async");
      @(negedge clk);
      check_reset_outputs("async_hold");
      reset_n = 1'b1;
      @(negedge clk);
      check("resume_h", 32'(hCount), 1);
      check("resume_v", 32'(vCount), 0);
      check("resume_ls", 32'(line_start), 0);
      pix_en = 1'b0;

      // frame wrap
      run_to(799, 524);
      check("fend_vsync", 32'(vsync), 1);
      check("fend_on", 32'(on), 0);
`ifdef VGA_FRAME_CNT_EN
      check("fend_fcnt", 32'(frame_cnt), 0);
`endif
      tick();
      check("fwrap_h", 32'(hCount), 0);
      check("fwrap_v", 32'(vCount), 0);
      check("fwrap_hsync", 32'(hsync), 0);
      check("fwrap_vsync", 32'(vsync), 0);
      check("fwrap_on", 32'(on), 0);
      check("fwrap_ls", 32'(line_start), 1);
      check("fwrap_fs", 32'(frame_start), 1);
`ifdef VGA_FRAME_CNT_EN
      check("fwrap_fcnt", 32'(frame_cnt), 1);
`endif
      @(negedge clk);
      check("fwrap_fs_drop", 32'(frame_start), 0);
      check("fwrap_ls_drop", 32'(line_start), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
